pc_context_store: RTL and testbench

// - Consumer/supplier opposite Program_counter: captures the process PC (only_proc_pc) into a per-process

---
 rtl/pc_context_store.sv | 154 +++++++++++++++
 tb/tb_pc_context_store.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_context_store.sv
// Per-process PC context table with a preemption quantum timer.
// Optional PC_CTX_PARITY_EN: one even-parity bit per slot, checked on load.
//
// state | meaning
// IDLE  | no process running; OS owns the PC
// RUN   | process running; instr_tick decrements the quantum
// SAVE  | quantum expired; store PC into cur_id, pulse preempt
// HALT  | process halted; store PC into cur_id, pulse done
module pc_context_store #(
  parameter int DATA_WIDTH    = 32,
  parameter int PID_WIDTH     = 3,
  parameter int QUANTUM_WIDTH = 16
) (
  input  logic                      clk_write,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PID_WIDTH-1:0]      start_id,
  input  logic [QUANTUM_WIDTH-1:0]  quantum_val,
  input  logic                      instr_tick,
  input  logic                      proc_hlt,
  input  logic                      save_req,
  input  logic [PID_WIDTH-1:0]      save_id,
  input  logic [DATA_WIDTH-1:0]     proc_pc_in,
  input  logic                      load_req,
  input  logic [PID_WIDTH-1:0]      load_id,
  output logic [DATA_WIDTH-1:0]     stored_pc,
  output logic                      load_valid,
  output logic                      proc_num,
  output logic [PID_WIDTH-1:0]      cur_id,
  output logic                      preempt,
  output logic                      done,
  output logic [2**PID_WIDTH-1:0]   slot_valid,
  output logic                      parity_err
);
  localparam int DEPTH = 2**PID_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, SAVE, HALT} state_t;

  state_t                     state_q, state_d;
  logic [QUANTUM_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PID_WIDTH-1:0]       cur_id_q, cur_id_d;
  logic                       proc_num_q, proc_num_d;
  logic [DATA_WIDTH-1:0]      stored_pc_q, stored_pc_d;
  logic                       load_valid_q, load_valid_d;
  logic [DEPTH-1:0]           slot_valid_q, slot_valid_d;
  logic [DATA_WIDTH-1:0]      table_q [DEPTH];
  logic [DATA_WIDTH-1:0]      table_d [DEPTH];
  logic                       fsm_wr;

  // State register and control flops
  always_ff @(posedge clk_write) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_id_q     <= '0;
      proc_num_q   <= 1'b0;
      stored_pc_q  <= '0;
      load_valid_q <= 1'b0;
      slot_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_id_q     <= cur_id_d;
      proc_num_q   <= proc_num_d;
      stored_pc_q  <= stored_pc_d;
      load_valid_q <= load_valid_d;
      slot_valid_q <= slot_valid_d;
    end
  end

  // Table contents survive reset; slot_valid gates stale entries.
  always_ff @(posedge clk_write) begin
    table_q <= table_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_id_d = cur_id_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_id_d = start_id;
          cnt_d    = quantum_val;
          state_d  = (quantum_val == '0) ? SAVE : RUN;
        end
      end
      RUN: begin
        if (proc_hlt) begin
          state_d = HALT;
        end else if (instr_tick && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == QUANTUM_WIDTH'(1)) state_d = SAVE;
        end
      end
      SAVE:    state_d = IDLE;
      HALT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    proc_num_d = (state_d == RUN);
  end

  // Output and table-update logic; the FSM write is applied last so it wins a collision.
  always_comb begin
    fsm_wr       = (state_q == SAVE) || (state_q == HALT);
    table_d      = table_q;
    slot_valid_d = slot_valid_q;
    if (save_req) begin
      table_d[save_id]      = proc_pc_in;
      slot_valid_d[save_id] = 1'b1;
    end
    if (fsm_wr) begin
      table_d[cur_id_q]      = proc_pc_in;
      slot_valid_d[cur_id_q] = 1'b1;
    end
    load_valid_d = load_req;
    stored_pc_d  = stored_pc_q;
    if (load_req) stored_pc_d = slot_valid_d[load_id] ? table_d[load_id] : '0;
  end

  assign preempt    = (state_q == SAVE);
  assign done       = (state_q == HALT);
  assign proc_num   = proc_num_q;
  assign cur_id     = cur_id_q;
  assign stored_pc  = stored_pc_q;
  assign load_valid = load_valid_q;
  assign slot_valid = slot_valid_q;

`ifdef PC_CTX_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             parity_err_q, parity_err_d;

  always_ff @(posedge clk_write) begin
    par_q <= par_d;
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  // Parity follows the same write priority, so bypassed data is always consistent.
  always_comb begin
    par_d = par_q;
    if (save_req) par_d[save_id]  = ^proc_pc_in;
    if (fsm_wr)   par_d[cur_id_q] = ^proc_pc_in;
    parity_err_d = load_req && slot_valid_d[load_id] &&
                   ((^table_d[load_id]) != par_d[load_id]);
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_context_store.sv
// Directed bench for pc_context_store: quantum preempt, halt, load/bypass, reset abort.
module tb_pc_context_store;
  logic        clk_write = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  start_id;
  logic [15:0] quantum_val;
  logic        instr_tick;
  logic        proc_hlt;
  logic        save_req;
  logic [2:0]  save_id;
  logic [31:0] proc_pc_in;
  logic        load_req;
  logic [2:0]  load_id;
  logic [31:0] stored_pc;
  logic        load_valid;
  logic        proc_num;
  logic [2:0]  cur_id;
  logic        preempt;
  logic        done;
  logic [7:0]  slot_valid;
  logic        parity_err;

  int n_tests = 0;
  int n_fail  = 0;

  pc_context_store dut (
    .clk_write(clk_write), .rst(rst), .start(start), .start_id(start_id),
    .quantum_val(quantum_val), .instr_tick(instr_tick), .proc_hlt(proc_hlt),
    .save_req(save_req), .save_id(save_id), .proc_pc_in(proc_pc_in),
    .load_req(load_req), .load_id(load_id), .stored_pc(stored_pc),
    .load_valid(load_valid), .proc_num(proc_num), .cur_id(cur_id),
    .preempt(preempt), .done(done), .slot_valid(slot_valid), .parity_err(parity_err)
  );

  always #5 clk_write = ~clk_write;

  task automatic step();
    @(posedge clk_write);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_id = '0; quantum_val = '0; instr_tick = 1'b0;
    proc_hlt = 1'b0; save_req = 1'b0; save_id = '0; proc_pc_in = '0;
    load_req = 1'b0; load_id = '0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_proc_num", 32'(proc_num), 32'd0);
    check("rst_stored_pc", stored_pc, 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_slot_valid", 32'(slot_valid), 32'd0);
    check("rst_preempt", 32'(preempt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cur_id", 32'(cur_id), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);

    // start id=2 q=3, three ticks -> preempt
    start = 1'b1; start_id = 3'd2; quantum_val = 16'd3;
    step();
    start = 1'b0;
    check("run_proc_num", 32'(proc_num), 32'd1);
    check("run_cur_id", 32'(cur_id), 32'd2);
    proc_pc_in = 32'h40; instr_tick = 1'b1;
    step(); step();
    check("tick2_no_preempt", 32'(preempt), 32'd0);
    step();
    instr_tick = 1'b0;
    check("q_preempt", 32'(preempt), 32'd1);
    check("q_proc_num", 32'(proc_num), 32'd0);
    check("q_done", 32'(done), 32'd0);
    step();
    check("q_preempt_end", 32'(preempt), 32'd0);
    check("q_slot_valid", 32'(slot_valid), 32'h04);

    // load slot 2, then never-saved slot 5
    load_req = 1'b1; load_id = 3'd2;
    step();
    load_req = 1'b0;
    check("ld2_pc", stored_pc, 32'h40);
    check("ld2_valid", 32'(load_valid), 32'd1);
    step();
    check("ld2_valid_pulse", 32'(load_valid), 32'd0);
    check("ld2_hold", stored_pc, 32'h40);
    load_req = 1'b1; load_id = 3'd5;
    step();
    load_req = 1'b0;
    check("ld5_pc", stored_pc, 32'd0);
    check("ld5_valid", 32'(load_valid), 32'd1);

    // start id=1 q=10, halt after two ticks
    start = 1'b1; start_id = 3'd1; quantum_val = 16'd10;
    step();
    start = 1'b0; instr_tick = 1'b1;
    step(); step();
    instr_tick = 1'b0; proc_hlt = 1'b1; proc_pc_in = 32'h1C;
    step();
    proc_hlt = 1'b0;
    check("hlt_done", 32'(done), 32'd1);
    check("hlt_no_preempt", 32'(preempt), 32'd0);
    check("hlt_proc_num", 32'(proc_num), 32'd0);
    step();
    check("hlt_slot_valid", 32'(slot_valid), 32'h06);
    check("hlt_done_end", 32'(done), 32'd0);
    load_req = 1'b1; load_id = 3'd1;
    step();
    load_req = 1'b0;
    check("ld1_pc", stored_pc, 32'h1C);

    // explicit save with same-cycle load bypass
    save_req = 1'b1; save_id = 3'd3; proc_pc_in = 32'h99;
    load_req = 1'b1; load_id = 3'd3;
    step();
    save_req = 1'b0; load_req = 1'b0;
    check("byp_pc", stored_pc, 32'h99);
    check("byp_valid", 32'(load_valid), 32'd1);
    check("byp_slot_valid", 32'(slot_valid), 32'h0E);

    // zero quantum -> immediate preempt
    start = 1'b1; start_id = 3'd4; quantum_val = 16'd0; proc_pc_in = 32'h123;
    step();
    start = 1'b0;
    check("q0_preempt", 32'(preempt), 32'd1);
    check("q0_proc_num", 32'(proc_num), 32'd0);
    check("q0_cur_id", 32'(cur_id), 32'd4);
    step();
    check("q0_slot_valid", 32'(slot_valid), 32'h1E);

    // quantum 1 holds without ticks, start ignored while running
    start = 1'b1; start_id = 3'd7; quantum_val = 16'd1;
    step();
    start_id = 3'd6;
    step();
    start = 1'b0;
    check("q1_wait_proc_num", 32'(proc_num), 32'd1);
    check("q1_wait_cur_id", 32'(cur_id), 32'd7);
    check("q1_wait_preempt", 32'(preempt), 32'd0);
    instr_tick = 1'b1; proc_pc_in = 32'h77;
    step();
    instr_tick = 1'b0;
    check("q1_preempt", 32'(preempt), 32'd1);
    step();
    load_req = 1'b1; load_id = 3'd7;
    step();
    load_req = 1'b0;
    check("ld7_pc", stored_pc, 32'h77);

    // reset mid-run with counter at 5
    start = 1'b1; start_id = 3'd6; quantum_val = 16'd9;
    step();
    start = 1'b0; instr_tick = 1'b1;
    step(); step(); step(); step();
    instr_tick = 1'b0;
    check("pre_rst_proc_num", 32'(proc_num), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_proc_num", 32'(proc_num), 32'd0);
    check("abort_preempt", 32'(preempt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_slot_valid", 32'(slot_valid), 32'd0);
    step();
    check("abort_preempt_late", 32'(preempt), 32'd0);
    load_req = 1'b1; load_id = 3'd2;
    step();
    load_req = 1'b0;
    check("ld2_after_rst", stored_pc, 32'd0);

`ifdef PC_CTX_PARITY_EN
    save_req = 1'b1; save_id = 3'd2; proc_pc_in = 32'h5A;
    step();
    save_req = 1'b0;
    load_req = 1'b1; load_id = 3'd2;
    step();
    load_req = 1'b0;
    check("par_clean", 32'(parity_err), 32'd0);
    dut.table_q[2] = dut.table_q[2] ^ 32'h1;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("par_err", 32'(parity_err), 32'd1);
    check("par_valid", 32'(load_valid), 32'd1);
    check("par_pc", stored_pc, 32'h5B);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
